// File: rtl/dm_responder_pkg.sv
// Shared constants and types for the multi-cycle data-memory responder.
// The state encodings, the memory base/size and the byte-merge helper live here.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_e;

  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam int          DM_WORDS = 3072;

  // Request fields captured at the accept edge; the low address bits are implied zero.
  typedef struct packed {
    logic        we;
    logic [29:0] word;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dmr_req_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store request bus between the M stage (master) and the data-memory responder (slave),
// plus a store-commit trace record the simulation environment prints.
interface dm_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_word;

  modport master (
    output req, we, addr, be, wdata, pc,
    input  ready, rvalid, rdata, err, trace_valid, trace_pc, trace_addr, trace_word
  );

  modport slave (
    input  req, we, addr, be, wdata, pc,
    output ready, rvalid, rdata, err, trace_valid, trace_pc, trace_addr, trace_word
  );
endinterface

// File: rtl/dm_store.sv
// Word array with byte-enable write, combinational read and asynchronous clear.
module dm_store
  import dm_responder_pkg::*;
#(
  parameter int DEPTH = DM_WORDS,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // Array storage: every word clears on reset, enabled bytes merge on write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (we) begin
      mem_r[idx] <= merge_bytes(mem_r[idx], wdata, be);
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one word request, commits it LATENCY edges later
// and answers with a single rvalid pulse; bad addresses answer one edge after accept with err.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_WORDS,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst,
  dm_responder_if.slave  bus
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [29:0] BASE_WORD = DM_BASE[31:2];

  dmr_state_e    state_r;
  dmr_state_e    next_state_s;
  dmr_req_t      req_r;
  logic          bad_r;
  logic [3:0]    cnt_r;
  logic [31:0]   rdata_r;
  logic          trace_valid_r;
  logic [31:0]   trace_pc_r;
  logic [31:0]   trace_addr_r;
  logic [31:0]   trace_word_r;

  logic [31:0]   off_s;
  logic          bad_s;
  logic          accept_s;
  logic          commit_s;
  logic          mem_we_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   mem_rd_s;
  logic          ready_s;
  logic          rvalid_s;
  logic          err_s;

  dm_store #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_s),
    .be    (req_r.be),
    .idx   (idx_s),
    .wdata (req_r.wdata),
    .rdata (mem_rd_s)
  );

  // Accept-time address check and commit qualifiers
  always_comb begin
    off_s    = bus.addr - DM_BASE;
    bad_s    = (bus.addr[1:0] != 2'b00) || (off_s >= LIMIT);
    accept_s = (state_r == DMR_IDLE) && bus.req;
    commit_s = (state_r == DMR_WAIT) && (cnt_r == 4'd0) && !bad_r;
    mem_we_s = commit_s && req_r.we;
    idx_s    = AW'(req_r.word - BASE_WORD);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= DMR_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; bad requests spend one WAIT cycle with the counter at zero
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      DMR_IDLE: begin
        if (bus.req) begin
          next_state_s = DMR_WAIT;
        end else begin
          next_state_s = DMR_IDLE;
        end
      end
      DMR_WAIT: begin
        if (cnt_r == 4'd0) begin
          next_state_s = DMR_RESP;
        end else begin
          next_state_s = DMR_WAIT;
        end
      end
      DMR_RESP: next_state_s = DMR_IDLE;
      default:  next_state_s = DMR_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    ready_s  = 1'b0;
    rvalid_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      DMR_IDLE: ready_s = 1'b1;
      DMR_WAIT: ready_s = 1'b0;
      DMR_RESP: begin
        rvalid_s = 1'b1;
        err_s    = bad_r;
      end
      default:  ready_s = 1'b0;
    endcase
  end

  // Request latch: inputs are sampled only at the accept edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_r <= '0;
      bad_r <= 1'b0;
    end else if (accept_s) begin
      req_r.we    <= bus.we;
      req_r.word  <= bus.addr[31:2];
      req_r.be    <= bus.be;
      req_r.wdata <= bus.wdata;
      req_r.pc    <= bus.pc;
      bad_r       <= bad_s;
    end
  end

  // Latency countdown: loaded on accept, runs down while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= bad_s ? 4'd0 : CNT_INIT;
    end else if ((state_r == DMR_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Load result register; holds between loads and across stores/errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= 32'd0;
    end else if (commit_s && !req_r.we) begin
      rdata_r <= mem_rd_s;
    end
  end

  // Store-commit trace record, valid alongside the response pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_valid_r <= 1'b0;
      trace_pc_r    <= 32'd0;
      trace_addr_r  <= 32'd0;
      trace_word_r  <= 32'd0;
    end else begin
      trace_valid_r <= mem_we_s && (req_r.be != 4'b0000);
      if (mem_we_s) begin
        trace_pc_r   <= req_r.pc;
        trace_addr_r <= {req_r.word, 2'b00};
        trace_word_r <= merge_bytes(mem_rd_s, req_r.wdata, req_r.be);
      end
    end
  end

  assign bus.ready       = ready_s;
  assign bus.rvalid      = rvalid_s;
  assign bus.err         = err_s;
  assign bus.rdata       = rdata_r;
  assign bus.trace_valid = trace_valid_r;
  assign bus.trace_pc    = trace_pc_r;
  assign bus.trace_addr  = trace_addr_r;
  assign bus.trace_word  = trace_word_r;

endmodule
